// File: rtl/tiny_fpga_pkg.sv
// Shared types and constants for the tiny_fpga_2x2 configuration path:
// the bitstream loader state encoding and the CRC-8 trailer definition.
package tiny_fpga_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERROR    = 3'd4
   } cfg_loader_state_e;

   localparam logic [7:0] CFG_CRC8_POLY = 8'h07;
   localparam logic [7:0] CFG_CRC8_INIT = 8'h00;

   // One bit of a CRC-8, MSB-first register, new bit fed into the top.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal stream interface (data/valid/ready) used for the fabric beat port.
interface axi_stream_if #(
   parameter int W = 1
) ();
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cfg_loader_crc8.sv
// Serial CRC-8 over W bits per enabled cycle, bit 0 of the beat first.
// crc_next is the value the register takes at the coming edge, so the
// caller can compare against the CRC including the beat in flight.
module cfg_loader_crc8
   import tiny_fpga_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] data,
   output logic [7:0]   crc_next
);

   logic [7:0] crc_q;
   logic [7:0] crc_upd;

   // Fold the beat's bits into the CRC in transmit order
   always_comb begin
      crc_upd = crc_q;
      for (int i = 0; i < W; i++) begin
         crc_upd = crc8_step(crc_upd, data[i]);
      end
   end

   assign crc_next = clear ? CFG_CRC8_INIT : (en ? crc_upd : crc_q);

   // CRC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= CFG_CRC8_INIT;
      else        crc_q <= crc_next;
   end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Byte-wide host stream to W-bit fabric beats for the tiny_fpga_2x2 config port.
// Drives the cfg strobe, waits for cfg_ready after the last beat and reports
// done/error. Optional CRC-8 trailer byte check: define CFG_LOADER_CRC_EN.
//
// Handshake: a transfer happens on any cycle where valid && ready are both
// high at the rising edge. The sender holds valid and data stable until that
// edge; ready may change freely. host_valid/host_ready and
// cfg_bitstream.valid/ready both follow this rule.
module cfg_bitstream_loader
   import tiny_fpga_pkg::*;
#(
   parameter int BITSTREAM_DATA_WIDTH = 1,
   parameter int BITSTREAM_LENGTH     = 128,
   parameter int READY_TIMEOUT        = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         host_data,
   input  logic               host_valid,
   input  logic               host_last,
   output logic               host_ready,
   output logic               cfg,
   axi_stream_if.master       cfg_bitstream,
   input  logic               cfg_ready,
   output logic               busy,
   output logic               done,
   output logic               error,
   output cfg_loader_state_e  dbg_state
);

   localparam int W     = BITSTREAM_DATA_WIDTH;
   localparam int LEN   = BITSTREAM_LENGTH;
   localparam int BPB   = 8 / W;
   localparam int CNT_W = $clog2(LEN + 1);
   localparam int TMO_W = $clog2(READY_TIMEOUT + 1);

   cfg_loader_state_e state;
   logic [7:0]        shift_q;
   logic [3:0]        beats_left;
   logic [CNT_W-1:0]  bit_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              cfg_q;
   logic              done_q;
   logic              error_q;

   logic              valid;
   logic              beat_fire;
   logic              shift_free;
   logic              img_ready;
   logic              img_take;
   logic              last_err;
   logic              img_finish;
   logic              start_take;
   logic              crc_ok;
   logic [CNT_W-1:0]  bits_after;
   int                img_left;
   logic [3:0]        load_beats;

   assign valid               = (state == ST_LOAD) && (beats_left != 4'd0);
   assign beat_fire           = valid && cfg_bitstream.ready;
   assign cfg_bitstream.valid = valid;
   assign cfg_bitstream.data  = shift_q[W-1:0];

   // The shift register can take a new byte when empty, or when its last beat
   // leaves this cycle, so consecutive bytes stream without a bubble.
   assign shift_free = (beats_left == 4'd0) || ((beats_left == 4'd1) && beat_fire);
   assign start_take = start && !abort &&
                       ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

   // Bit count after this cycle's beat, image bits still owed, beats in the next byte
   always_comb begin
      bits_after = bit_cnt;
      if (beat_fire && (bit_cnt < CNT_W'(LEN))) bits_after = bit_cnt + CNT_W'(W);
      img_left = LEN - int'(bits_after);
      if (img_left >= 8) load_beats = 4'(BPB);
      else               load_beats = 4'(img_left / W);
   end

   assign img_ready = (state == ST_LOAD) && shift_free && (img_left > 0);
   assign img_take  = img_ready && host_valid;

`ifdef CFG_LOADER_CRC_EN
   logic       trl_got;
   logic [7:0] trl_q;
   logic       trl_ready;
   logic       trl_take;
   logic [7:0] crc_next;
   logic [7:0] trl_byte;

   // The trailer is accepted once the final image beat has gone (or goes now)
   assign trl_ready  = (state == ST_LOAD) && (img_left == 0) && !trl_got;
   assign trl_take   = trl_ready && host_valid;
   assign trl_byte   = trl_got ? trl_q : host_data;
   assign host_ready = img_ready || trl_ready;
   assign last_err   = (img_take && host_last) || (trl_take && !host_last);
   assign img_finish = (img_left == 0) && (trl_got || trl_take);
   assign crc_ok     = (crc_next == trl_byte);

   cfg_loader_crc8 #(.W(W)) u_crc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start_take),
      .en       (beat_fire),
      .data     (shift_q[W-1:0]),
      .crc_next (crc_next)
   );
`else
   assign host_ready = img_ready;
   // host_last must mark exactly the byte holding the final image bit
   assign last_err   = img_take && (host_last ? (img_left > 8) : (img_left <= 8));
   assign img_finish = (img_left == 0);
   assign crc_ok     = 1'b1;
`endif

   assign cfg       = cfg_q;
   assign done      = done_q;
   assign error     = error_q;
   assign busy      = (state == ST_LOAD) || (state == ST_WAIT_RDY);
   assign dbg_state = state;

   // Load sequencer: serialiser, bit/timeout counters and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         shift_q    <= 8'h00;
         beats_left <= 4'd0;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         cfg_q      <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
         trl_got    <= 1'b0;
         trl_q      <= 8'h00;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_take) begin
                  state      <= ST_LOAD;
                  cfg_q      <= 1'b1;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  shift_q    <= 8'h00;
                  beats_left <= 4'd0;
                  bit_cnt    <= '0;
                  tmo_cnt    <= '0;
`ifdef CFG_LOADER_CRC_EN
                  trl_got    <= 1'b0;
`endif
               end else if (abort && (state != ST_IDLE)) begin
                  state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state      <= ST_IDLE;
                  cfg_q      <= 1'b0;
                  beats_left <= 4'd0;
               end else begin
                  if (beat_fire) begin
                     shift_q    <= shift_q >> W;
                     beats_left <= 4'(beats_left - 4'd1);
                     bit_cnt    <= bits_after;
                  end
                  if (img_take) begin
                     shift_q    <= host_data;
                     beats_left <= load_beats;
                  end
`ifdef CFG_LOADER_CRC_EN
                  if (trl_take) begin
                     trl_got <= 1'b1;
                     trl_q   <= host_data;
                  end
`endif
                  if (last_err || (img_finish && !crc_ok)) begin
                     state      <= ST_ERROR;
                     error_q    <= 1'b1;
                     cfg_q      <= 1'b0;
                     beats_left <= 4'd0;
                  end else if (img_finish) begin
                     state   <= ST_WAIT_RDY;
                     tmo_cnt <= '0;
                  end
               end
            end
            ST_WAIT_RDY: begin
               if (abort) begin
                  state <= ST_IDLE;
                  cfg_q <= 1'b0;
               end else if (cfg_ready) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  cfg_q  <= 1'b0;
               end else if (tmo_cnt == TMO_W'(READY_TIMEOUT - 1)) begin
                  state   <= ST_ERROR;
                  error_q <= 1'b1;
                  cfg_q   <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cfg_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader. Two instances share the stimulus:
// dut_a (W=1, LEN=16) and dut_b (W=1, LEN=12); sel picks which one is observed.
// Builds with or without CFG_LOADER_CRC_EN.
module tb_cfg_bitstream_loader;
   import tiny_fpga_pkg::*;

   localparam int W   = 1;
   localparam int TMO = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic host_valid = 1'b0;
   logic host_last = 1'b0;
   logic [7:0] host_data = 8'h00;
   logic cfg_ready = 1'b0;
   logic f_ready = 1'b1;
   logic sel = 1'b0;

   logic hr_a, cfg_a, busy_a, done_a, err_a;
   logic hr_b, cfg_b, busy_b, done_b, err_b;
   cfg_loader_state_e st_a, st_b;

   axi_stream_if #(.W(W)) bs_a ();
   axi_stream_if #(.W(W)) bs_b ();
   assign bs_a.ready = f_ready;
   assign bs_b.ready = f_ready;

   cfg_bitstream_loader #(.BITSTREAM_DATA_WIDTH(W), .BITSTREAM_LENGTH(16), .READY_TIMEOUT(TMO)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .host_data(host_data), .host_valid(host_valid), .host_last(host_last), .host_ready(hr_a),
      .cfg(cfg_a), .cfg_bitstream(bs_a), .cfg_ready(cfg_ready),
      .busy(busy_a), .done(done_a), .error(err_a), .dbg_state(st_a)
   );

   cfg_bitstream_loader #(.BITSTREAM_DATA_WIDTH(W), .BITSTREAM_LENGTH(12), .READY_TIMEOUT(TMO)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .host_data(host_data), .host_valid(host_valid), .host_last(host_last), .host_ready(hr_b),
      .cfg(cfg_b), .cfg_bitstream(bs_b), .cfg_ready(cfg_ready),
      .busy(busy_b), .done(done_b), .error(err_b), .dbg_state(st_b)
   );

   // Observed instance
   logic t_hr, t_cfg, t_busy, t_done, t_err, t_valid;
   logic [W-1:0] t_data;
   cfg_loader_state_e t_st;
   assign t_hr    = sel ? hr_b : hr_a;
   assign t_cfg   = sel ? cfg_b : cfg_a;
   assign t_busy  = sel ? busy_b : busy_a;
   assign t_done  = sel ? done_b : done_a;
   assign t_err   = sel ? err_b : err_a;
   assign t_valid = sel ? bs_b.valid : bs_a.valid;
   assign t_data  = sel ? bs_b.data : bs_a.data;
   assign t_st    = sel ? st_b : st_a;

   // Clock
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [8:0]   host_q[$];
   logic [W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; host_valid = 1'b0; host_last = 1'b0;
      host_data = 8'h00; cfg_ready = 1'b0; f_ready = 1'b1;
      host_q.delete(); exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_exp(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
   endtask

`ifdef CFG_LOADER_CRC_EN
   function automatic logic [7:0] crc_bits(input logic [15:0] bits, input int n);
      logic [7:0] c;
      logic fb;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         fb = c[7] ^ bits[i];
         c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction
`endif

   // Two-byte image; last_ok sets host_last on the byte that should carry it
   task automatic push_img(input logic [7:0] b0, input logic [7:0] b1, input logic last_ok);
`ifdef CFG_LOADER_CRC_EN
      host_q.push_back({1'b0, b0});
      host_q.push_back({1'b0, b1});
      host_q.push_back({last_ok, crc_bits({b1, b0}, sel ? 12 : 16)});
`else
      host_q.push_back({1'b0, b0});
      host_q.push_back({last_ok, b1});
`endif
   endtask

   // Drive host bytes and fabric ready until the observed DUT leaves LOAD
   // (ends at the negedge of the first non-LOAD cycle) or stop_beats beats went.
   task automatic run_load(input bit stall, input int stop_beats, output int load_cyc, output int nbeats);
      bit prev_hold;
      logic [W-1:0] prev_data;
      bit finished;
      prev_hold = 1'b0; prev_data = '0; finished = 1'b0; load_cyc = 0; nbeats = 0;
      for (int c = 0; c < 300 && !finished; c++) begin
         host_valid = (host_q.size() != 0);
         host_data  = host_valid ? host_q[0][7:0] : 8'h00;
         host_last  = host_valid ? host_q[0][8] : 1'b0;
         f_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (t_st != ST_LOAD) begin
            finished = 1'b1;
         end else begin
            load_cyc++;
            if (prev_hold) begin
               chk("hold_valid", 32'(t_valid), 32'd1);
               chk("hold_data", 32'(t_data), 32'(prev_data));
            end
            prev_hold = t_valid && !f_ready;
            prev_data = t_data;
            if (t_valid && f_ready) begin
               nbeats++;
               chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) chk("beat_data", 32'(t_data), 32'(exp_q.pop_front()));
            end
            if (host_valid && t_hr) void'(host_q.pop_front());
            if (stop_beats > 0 && nbeats == stop_beats) finished = 1'b1;
            @(posedge clk); #1;
         end
      end
      host_valid = 1'b0; host_last = 1'b0; host_data = 8'h00; f_ready = 1'b1;
      chk("load_in_budget", 32'(finished), 32'd1);
   endtask

   // Count cycles spent in WAIT_RDY (starting and ending at a negedge)
   task automatic count_wait(output int n);
      n = 0;
      while (n < 200 && t_st == ST_WAIT_RDY) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic ready_pulse();
      cfg_ready = 1'b1;
      @(posedge clk); #1;
      cfg_ready = 1'b0;
   endtask

   int lc, nb, nw;

   initial begin
      // ---- reset state ----
      sel = 1'b0;
      do_reset();
      chk("rst_state", 32'(t_st), 32'(ST_IDLE));
      chk("rst_cfg", 32'(t_cfg), 32'd0);
      chk("rst_busy", 32'(t_busy), 32'd0);
      chk("rst_done", 32'(t_done), 32'd0);
      chk("rst_error", 32'(t_err), 32'd0);
      chk("rst_host_ready", 32'(t_hr), 32'd0);
      chk("rst_valid", 32'(t_valid), 32'd0);

      // ---- 1: 0xA5, 0x3C, ready always high ----
      pulse_start();
      chk("t1_cfg_rise", 32'(t_cfg), 32'd1);
      chk("t1_busy", 32'(t_busy), 32'd1);
      push_img(8'hA5, 8'h3C, 1'b1);
      load_exp(32'h3CA5, 16);
      run_load(1'b0, 0, lc, nb);
      chk("t1_load_cycles", 32'(lc), 32'd17);
      chk("t1_beats", 32'(nb), 32'd16);
      chk("t1_exp_left", 32'(exp_q.size()), 32'd0);
      chk("t1_wait_state", 32'(t_st), 32'(ST_WAIT_RDY));
      chk("t1_wait_cfg", 32'(t_cfg), 32'd1);
      chk("t1_wait_done", 32'(t_done), 32'd0);
      ready_pulse();
      chk("t1_done_state", 32'(t_st), 32'(ST_DONE));
      chk("t1_done", 32'(t_done), 32'd1);
      chk("t1_error", 32'(t_err), 32'd0);
      chk("t1_cfg_low", 32'(t_cfg), 32'd0);
      chk("t1_busy_low", 32'(t_busy), 32'd0);
      chk("t1_host_ready_low", 32'(t_hr), 32'd0);

      // ---- 2: random fabric stalls, cfg_ready high during LOAD ----
      pulse_start();
      chk("t2_done_cleared", 32'(t_done), 32'd0);
      cfg_ready = 1'b1;
      push_img(8'hA5, 8'h3C, 1'b1);
      load_exp(32'h3CA5, 16);
      run_load(1'b1, 0, lc, nb);
      chk("t2_beats", 32'(nb), 32'd16);
      chk("t2_exp_left", 32'(exp_q.size()), 32'd0);
      chk("t2_wait_state", 32'(t_st), 32'(ST_WAIT_RDY));
      @(posedge clk); #1;
      cfg_ready = 1'b0;
      chk("t2_done", 32'(t_done), 32'd1);

      // ---- 4: cfg_ready never arrives ----
      pulse_start();
      push_img(8'hA5, 8'h3C, 1'b1);
      load_exp(32'h3CA5, 16);
      run_load(1'b0, 0, lc, nb);
      count_wait(nw);
      chk("t4_wait_cycles", 32'(nw), 32'(TMO));
      chk("t4_state", 32'(t_st), 32'(ST_ERROR));
      chk("t4_error", 32'(t_err), 32'd1);
      chk("t4_done", 32'(t_done), 32'd0);
      chk("t4_cfg_low", 32'(t_cfg), 32'd0);

      // ---- 5: abort after 5 beats, then a clean reload ----
      pulse_start();
      chk("t5_error_cleared", 32'(t_err), 32'd0);
      push_img(8'hA5, 8'h3C, 1'b1);
      load_exp(32'h3CA5, 16);
      run_load(1'b0, 5, lc, nb);
      chk("t5_beats_before_abort", 32'(nb), 32'd5);
      abort = 1'b1;
      @(negedge clk);
      chk("t5_cfg_before_edge", 32'(t_cfg), 32'd1);
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t5_abort_state", 32'(t_st), 32'(ST_IDLE));
      chk("t5_abort_cfg", 32'(t_cfg), 32'd0);
      chk("t5_abort_valid", 32'(t_valid), 32'd0);
      chk("t5_abort_busy", 32'(t_busy), 32'd0);
      host_q.delete();
      exp_q.delete();
      pulse_start();
      push_img(8'hA5, 8'h3C, 1'b1);
      load_exp(32'h3CA5, 16);
      run_load(1'b0, 0, lc, nb);
      chk("t5_reload_beats", 32'(nb), 32'd16);
      chk("t5_reload_state", 32'(t_st), 32'(ST_WAIT_RDY));
      ready_pulse();
      chk("t5_reload_done", 32'(t_done), 32'd1);

`ifdef CFG_LOADER_CRC_EN
      // ---- 6: corrupted CRC trailer ----
      pulse_start();
      host_q.push_back({1'b0, 8'hA5});
      host_q.push_back({1'b0, 8'h3C});
      host_q.push_back({1'b1, crc_bits(16'h3CA5, 16) ^ 8'h01});
      load_exp(32'h3CA5, 16);
      run_load(1'b0, 0, lc, nb);
      chk("t6_beats", 32'(nb), 32'd16);
      chk("t6_state", 32'(t_st), 32'(ST_ERROR));
      chk("t6_error", 32'(t_err), 32'd1);
      chk("t6_done", 32'(t_done), 32'd0);
      chk("t6_cfg_low", 32'(t_cfg), 32'd0);
`endif

      // ---- 3: LEN=12 partial final byte and host_last errors ----
      sel = 1'b1;
      do_reset();
      pulse_start();
      push_img(8'hFF, 8'h0F, 1'b1);
      load_exp(32'h0FFF, 12);
      run_load(1'b0, 0, lc, nb);
      chk("t3_load_cycles", 32'(lc), 32'd13);
      chk("t3_beats", 32'(nb), 32'd12);
      chk("t3_exp_left", 32'(exp_q.size()), 32'd0);
      chk("t3_wait_state", 32'(t_st), 32'(ST_WAIT_RDY));
      ready_pulse();
      chk("t3_done", 32'(t_done), 32'd1);

      pulse_start();
      host_q.push_back({1'b1, 8'hFF});
      run_load(1'b0, 0, lc, nb);
      chk("t3_early_last_beats", 32'(nb), 32'd0);
      chk("t3_early_last_state", 32'(t_st), 32'(ST_ERROR));
      chk("t3_early_last_error", 32'(t_err), 32'd1);
      chk("t3_early_last_done", 32'(t_done), 32'd0);
      chk("t3_early_last_cfg", 32'(t_cfg), 32'd0);
      host_q.delete();

      pulse_start();
      push_img(8'hFF, 8'h0F, 1'b0);
`ifdef CFG_LOADER_CRC_EN
      load_exp(32'h0FFF, 12);
`else
      load_exp(32'h00FF, 8);
`endif
      run_load(1'b0, 0, lc, nb);
      chk("t3_no_last_exp_left", 32'(exp_q.size()), 32'd0);
      chk("t3_no_last_state", 32'(t_st), 32'(ST_ERROR));
      chk("t3_no_last_error", 32'(t_err), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
